// File: rtl/i2c_gpio_expander.sv
`timescale 1ns/1ps
// Simulation model of a TCA95xx-style I2C GPIO expander with NUM_PORTS 8-bit ports,
// pointer auto-increment, polarity inversion and an input-change interrupt.
module i2c_gpio_expander #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_PINS = 2,
  parameter logic [6:0]  BASE_ADDR = 7'h74,
  parameter int unsigned FILTER    = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  output wire                                   int_n,
  input  logic                                  scl,
  inout  wire                                   sda,
  input  logic [(ADDR_PINS > 0 ? ADDR_PINS : 1)-1:0] addr,
  inout  wire  [8*NUM_PORTS-1:0]                port
);
  localparam int unsigned PW    = 8 * NUM_PORTS;
  localparam int unsigned IW    = $clog2(PW);
  localparam int unsigned PL    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 0;
  localparam int unsigned CW    = $clog2(FILTER + 1);
  localparam logic [4:0]  PMASK = 5'(NUM_PORTS - 1);
  localparam logic [7:0]  NREG  = 8'(4 * NUM_PORTS);
  localparam logic [6:0]  AMASK = 7'((1 << ADDR_PINS) - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_CMD, ST_CMD_ACK,
    ST_WRITE, ST_WRITE_ACK, ST_READ, ST_READ_MACK, ST_READ_LOAD
  } state_t;

  state_t         state_q;
  logic [1:0]     sync1_q, sync2_q, filt_q, prev_q;
  logic [CW-1:0]  fcnt_q [2];
  logic           fall_d_q, sda_low_q, ack_on_q, rw_q, ref_init_q;
  logic [2:0]     cnt_q;
  logic [7:0]     sh_q;
  logic [4:0]     ptr_q;
  logic [PW-1:0]  out_q, pol_q, cfg_q, ref_q;

  logic [PW-1:0]  pins;
  logic [6:0]     my_addr;
  logic           scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c, snap;
  logic [1:0]     grp;
  logic [IW-1:0]  pbase;
  logic [4:0]     ptr_inc;
  logic [7:0]     byte_in, rdata;

  assign pins     = port;
  assign my_addr  = (BASE_ADDR & ~AMASK) | (7'(addr) & AMASK);
  assign scl_f    = filt_q[0];
  assign sda_f    = filt_q[1];
  assign scl_rise = scl_f & ~prev_q[0];
  assign scl_fall = ~scl_f & prev_q[0];
  assign start_c  = scl_f & prev_q[0] & prev_q[1] & ~sda_f;
  assign stop_c   = scl_f & prev_q[0] & ~prev_q[1] & sda_f;
  assign grp      = 2'(ptr_q >> PL);
  assign pbase    = IW'({ptr_q & PMASK, 3'b000});
  assign ptr_inc  = (ptr_q & ~PMASK) | ((ptr_q + 5'd1) & PMASK);
  assign byte_in  = {sh_q[6:0], sda_f};
  assign snap     = fall_d_q && ((state_q == ST_ADDR_ACK && ack_on_q && rw_q) ||
                                 state_q == ST_READ_LOAD);

  always_comb begin
    rdata = '0;
    unique case (grp)
      2'd0:    rdata = pins[pbase +: 8] ^ pol_q[pbase +: 8];
      2'd1:    rdata = out_q[pbase +: 8];
      2'd2:    rdata = pol_q[pbase +: 8];
      default: rdata = cfg_q[pbase +: 8];
    endcase
  end

  // A line change is accepted only after FILTER consecutive synced samples disagree with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      filt_q  <= '1;
      prev_q  <= '1;
      for (int unsigned i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q <= {sda, scl};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CW'(FILTER - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      fall_d_q   <= 1'b0;
      sda_low_q  <= 1'b0;
      ack_on_q   <= 1'b0;
      rw_q       <= 1'b0;
      cnt_q      <= '0;
      sh_q       <= '0;
      ptr_q      <= '0;
      out_q      <= '1;
      pol_q      <= '0;
      cfg_q      <= '1;
      ref_q      <= '0;
      ref_init_q <= 1'b1;
    end else begin
      fall_d_q <= scl_fall;
      if (ref_init_q) begin
        ref_q      <= pins;
        ref_init_q <= 1'b0;
      end
      if (start_c) begin
        state_q   <= ST_ADDR;
        cnt_q     <= '0;
        sda_low_q <= 1'b0;
        ack_on_q  <= 1'b0;
      end else if (stop_c) begin
        state_q   <= ST_IDLE;
        sda_low_q <= 1'b0;
        ack_on_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_ADDR, ST_CMD, ST_WRITE: if (scl_rise) begin
            sh_q  <= byte_in;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                rw_q    <= sda_f;
                state_q <= (sh_q[6:0] == my_addr) ? ST_ADDR_ACK : ST_IDLE;
              end else if (state_q == ST_CMD) begin
                if (byte_in < NREG) ptr_q <= byte_in[4:0];
                state_q <= (byte_in < NREG) ? ST_CMD_ACK : ST_IDLE;
              end else begin
                state_q <= ST_WRITE_ACK;
              end
            end
          end
          ST_ADDR_ACK, ST_CMD_ACK, ST_WRITE_ACK: begin
            // First delayed fall after the byte starts the ACK, the second ends it.
            if (fall_d_q) begin
              sda_low_q <= ~ack_on_q;
              ack_on_q  <= ~ack_on_q;
              if (ack_on_q) begin
                if (state_q == ST_CMD_ACK || state_q == ST_WRITE_ACK) state_q <= ST_WRITE;
                else if (!rw_q) state_q <= ST_CMD;
              end
            end
            if (scl_rise && ack_on_q && state_q == ST_WRITE_ACK) begin
              unique case (grp)
                2'd1:    out_q[pbase +: 8] <= sh_q;
                2'd2:    pol_q[pbase +: 8] <= sh_q;
                2'd3:    cfg_q[pbase +: 8] <= sh_q;
                default: ;
              endcase
              ptr_q <= ptr_inc;
            end
          end
          ST_READ: begin
            if (fall_d_q) begin
              sh_q      <= {sh_q[6:0], 1'b0};
              sda_low_q <= ~sh_q[6];
            end
            if (scl_rise) begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) state_q <= ST_READ_MACK;
            end
          end
          ST_READ_MACK: begin
            if (fall_d_q) sda_low_q <= 1'b0;
            if (scl_rise) begin
              if (!sda_f) ptr_q <= ptr_inc;
              state_q <= sda_f ? ST_IDLE : ST_READ_LOAD;
            end
          end
          default: ;
        endcase
        if (snap) begin
          sh_q      <= rdata;
          sda_low_q <= ~rdata[7];
          cnt_q     <= '0;
          state_q   <= ST_READ;
          if (grp == 2'd0) ref_q[pbase +: 8] <= pins[pbase +: 8];
        end
      end
    end
  end

  for (genvar i = 0; i < PW; i++) begin : g_pin
    assign port[i] = cfg_q[i] ? 1'bz : out_q[i];
  end

  assign sda   = (sda_low_q && reset_n) ? 1'b0 : 1'bz;
  assign int_n = (reset_n && !ref_init_q && |((pins ^ ref_q) & cfg_q)) ? 1'b0 : 1'bz;

endmodule
